// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage for the data memory: synchronous write, registered read,
// contents deliberately left without a reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // Write on request, and capture the read word only when a load is accepted
  // so the output stays stable while the response waits to be consumed.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline MEM stage: accepts one load/store at
// a time, answers after a fixed LATENCY and holds the response until consumed.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned requests complete with an
// error response and never write the array.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [WORD_W-1:0] req_addr_i,
  input  logic [WORD_W-1:0] req_wdata_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [WORD_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int AW = $clog2(DEPTH);

  state_t            r_state;
  state_t            w_stateNext;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cntNext;
  logic              r_isLoad;
  logic              w_accept;
  logic              w_misaligned;
  logic [WORD_W-1:0] w_arrRdata;
  logic [AW-1:0]     w_index;

  assign w_accept = req_valid_i && (r_state == IDLE);
  assign w_index  = req_addr_i[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_err;
  logic w_unused_addr;

  assign w_misaligned  = |req_addr_i[1:0];
  assign w_unused_addr = &{1'b0, req_addr_i[WORD_W-1:AW+2]};

  // Remember whether the accepted request was misaligned.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_misaligned;
    end
  end

  assign rsp_err_o = (r_state == RESP) && r_err;
`else
  logic w_unused_addr;

  assign w_misaligned  = 1'b0;
  assign w_unused_addr = &{1'b0, req_addr_i[WORD_W-1:AW+2], req_addr_i[1:0]};
  assign rsp_err_o     = 1'b0;
`endif

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .i_clk   (clk_i),
    .i_we    (w_accept && req_write_i && !w_misaligned),
    .i_re    (w_accept && !req_write_i),
    .i_addr  (w_index),
    .i_wdata (req_wdata_i),
    .o_rdata (w_arrRdata)
  );

  // Next-state and latency counter: accept only in IDLE, count down in WAIT,
  // hold the response in RESP until the consumer takes it.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_stateNext = RESP;
            w_cntNext   = '0;
          end else begin
            w_stateNext = WAIT;
            w_cntNext   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_stateNext = RESP;
        end else begin
          w_cntNext = r_cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  // State register, counter and the load/store flag of the pending response.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_isLoad <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      if (w_accept) begin
        r_isLoad <= !req_write_i && !w_misaligned;
      end
    end
  end

  assign req_ready_o = (r_state == IDLE);
  assign rsp_valid_o = (r_state == RESP);
  assign rsp_rdata_o = (rsp_valid_o && r_isLoad) ? w_arrRdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder: one LATENCY=2 instance for the main
// scenarios and one LATENCY=1 instance for back-to-back traffic.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;

  logic        reqValid, reqWrite, reqReady, rspValid, rspReady, rspErr;
  logic [31:0] reqAddr, reqWdata, rspRdata;

  logic        reqValidB, reqWriteB, reqReadyB, rspValidB, rspReadyB, rspErrB;
  logic [31:0] reqAddrB, reqWdataB, rspRdataB;

  int nCompared;
  int nMismatched;

  dmem_responder #(.DEPTH(128), .LATENCY(2)) dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .req_valid_i (reqValid),
    .req_write_i (reqWrite),
    .req_addr_i  (reqAddr),
    .req_wdata_i (reqWdata),
    .req_ready_o (reqReady),
    .rsp_valid_o (rspValid),
    .rsp_ready_i (rspReady),
    .rsp_rdata_o (rspRdata),
    .rsp_err_o   (rspErr)
  );

  dmem_responder #(.DEPTH(128), .LATENCY(1)) dutB (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .req_valid_i (reqValidB),
    .req_write_i (reqWriteB),
    .req_addr_i  (reqAddrB),
    .req_wdata_i (reqWdataB),
    .req_ready_o (reqReadyB),
    .rsp_valid_o (rspValidB),
    .rsp_ready_i (rspReadyB),
    .rsp_rdata_o (rspRdataB),
    .rsp_err_o   (rspErrB)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present a request now, let it be accepted on the next edge, then drop it.
  task automatic issueReq(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    reqValid = 1'b1;
    reqWrite = wr;
    reqAddr  = addr;
    reqWdata = data;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
  endtask

  // Count edges from the accept edge until rsp_valid is seen (bounded).
  task automatic waitValid(output int n);
    n = 1;
    @(posedge clk);
    #1;
    while (!rspValid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Consume the pending response with a one-cycle rsp_ready pulse.
  task automatic finishRsp();
    rspReady = 1'b1;
    @(posedge clk);
    #1;
    rspReady = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    nCompared++;
    if (reqReady !== 1'b1 || rspValid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_handshake got ready=%b valid=%b expected ready=1 valid=0", reqReady, rspValid);
    end
    nCompared++;
    if (rspRdata !== 32'h0 || rspErr !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_data got rdata=%h err=%b expected 0/0", rspRdata, rspErr);
    end
    nCompared++;
    if (reqReadyB !== 1'b1 || rspValidB !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_b got ready=%b valid=%b expected 1/0", reqReadyB, rspValidB);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load();
    int n;
    issueReq(1'b1, 32'h10, 32'hDEADBEEF);
    waitValid(n);
    nCompared++;
    if (n !== 2) begin
      nMismatched++;
      $display("[TB] FAIL store_latency got %0d expected 2", n);
    end
    nCompared++;
    if (rspRdata !== 32'h0 || rspErr !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL store_rsp got rdata=%h err=%b expected 0/0", rspRdata, rspErr);
    end
    finishRsp();
    issueReq(1'b0, 32'h10, 32'h0);
    waitValid(n);
    nCompared++;
    if (n !== 2) begin
      nMismatched++;
      $display("[TB] FAIL load_latency got %0d expected 2", n);
    end
    nCompared++;
    if (rspRdata !== 32'hDEADBEEF) begin
      nMismatched++;
      $display("[TB] FAIL load_data got %h expected deadbeef", rspRdata);
    end
    finishRsp();
  endtask

  // Stall the response 5 cycles while a competing store is offered; it must be ignored.
  task automatic test_hold();
    int n;
    issueReq(1'b0, 32'h10, 32'h0);
    waitValid(n);
    for (int i = 0; i < 5; i++) begin
      reqValid = 1'b1;
      reqWrite = 1'b1;
      reqAddr  = 32'h10;
      reqWdata = 32'h00000BAD;
      @(posedge clk);
      #1;
      nCompared++;
      if (rspValid !== 1'b1 || reqReady !== 1'b0 || rspRdata !== 32'hDEADBEEF) begin
        nMismatched++;
        $display("[TB] FAIL hold_cycle%0d got valid=%b ready=%b rdata=%h expected 1/0/deadbeef",
                 i, rspValid, reqReady, rspRdata);
      end
    end
    reqValid = 1'b0;
    finishRsp();
    nCompared++;
    if (reqReady !== 1'b1 || rspValid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL hold_release got ready=%b valid=%b expected 1/0", reqReady, rspValid);
    end
    issueReq(1'b0, 32'h10, 32'h0);
    waitValid(n);
    nCompared++;
    if (rspRdata !== 32'hDEADBEEF) begin
      nMismatched++;
      $display("[TB] FAIL ignored_write got %h expected deadbeef", rspRdata);
    end
    finishRsp();
  endtask

  task automatic test_wrap();
    int n;
    issueReq(1'b1, 32'h200, 32'h00001234);
    waitValid(n);
    finishRsp();
    issueReq(1'b0, 32'h000, 32'h0);
    waitValid(n);
    nCompared++;
    if (rspRdata !== 32'h00001234) begin
      nMismatched++;
      $display("[TB] FAIL wrap_load0 got %h expected 00001234", rspRdata);
    end
    finishRsp();
    issueReq(1'b0, 32'hFFFF_0210, 32'h0);
    waitValid(n);
    nCompared++;
    if (rspRdata !== 32'hDEADBEEF) begin
      nMismatched++;
      $display("[TB] FAIL wrap_load4 got %h expected deadbeef", rspRdata);
    end
    finishRsp();
  endtask

  task automatic test_align();
    int n;
    logic        expErr;
    logic [31:0] expWord;
`ifdef DMEM_ALIGN_CHECK_EN
    expErr  = 1'b1;
    expWord = 32'hDEADBEEF;
`else
    expErr  = 1'b0;
    expWord = 32'h0000CAFE;
`endif
    issueReq(1'b1, 32'h13, 32'h0000CAFE);
    waitValid(n);
    nCompared++;
    if (n !== 2 || rspErr !== expErr || rspRdata !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL align_store got lat=%0d err=%b rdata=%h expected 2/%b/0",
               n, rspErr, rspRdata, expErr);
    end
    finishRsp();
    issueReq(1'b0, 32'h10, 32'h0);
    waitValid(n);
    nCompared++;
    if (rspRdata !== expWord || rspErr !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL align_load got rdata=%h err=%b expected %h/0", rspRdata, rspErr, expWord);
    end
    finishRsp();
  endtask

  task automatic test_reset_wait();
    int n;
    issueReq(1'b1, 32'h20, 32'h00000777);
    nCompared++;
    if (rspValid !== 1'b0 || reqReady !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL in_wait got valid=%b ready=%b expected 0/0", rspValid, reqReady);
    end
    rst_n = 1'b0;
    #1;
    nCompared++;
    if (rspValid !== 1'b0 || rspRdata !== 32'h0 || rspErr !== 1'b0 || reqReady !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL reset_in_wait got valid=%b rdata=%h err=%b ready=%b expected 0/0/0/1",
               rspValid, rspRdata, rspErr, reqReady);
    end
    #1;
    rst_n = 1'b1;
    nCompared++;
    if (reqReady !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL ready_after_reset got %b expected 1", reqReady);
    end
    issueReq(1'b0, 32'h20, 32'h0);
    waitValid(n);
    nCompared++;
    if (n !== 2 || rspRdata !== 32'h00000777) begin
      nMismatched++;
      $display("[TB] FAIL post_reset_load got lat=%0d rdata=%h expected 2/00000777", n, rspRdata);
    end
    finishRsp();
  endtask

  // LATENCY=1, rsp_ready held high, request valid held high: 8 stores then
  // 8 loads, one accept every second cycle.
  task automatic test_back_to_back();
    int          nRsp;
    logic [31:0] exp;
    nRsp      = 0;
    rspReadyB = 1'b1;
    reqValidB = 1'b1;
    for (int i = 0; i < 16; i++) begin
      nCompared++;
      if (reqReadyB !== 1'b1 || rspValidB !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL b2b_idle%0d got ready=%b valid=%b expected 1/0", i, reqReadyB, rspValidB);
      end
      reqWriteB = (i < 8);
      reqAddrB  = 32'((i % 8) * 4);
      reqWdataB = 32'hA5A5_0000 + 32'(i % 8);
      exp       = (i < 8) ? 32'h0 : (32'hA5A5_0000 + 32'(i % 8));
      @(posedge clk);
      #1;
      nCompared++;
      if (rspValidB !== 1'b1 || reqReadyB !== 1'b0 || rspRdataB !== exp) begin
        nMismatched++;
        $display("[TB] FAIL b2b_rsp%0d got valid=%b ready=%b rdata=%h expected 1/0/%h",
                 i, rspValidB, reqReadyB, rspRdataB, exp);
      end
      if (rspValidB === 1'b1) begin
        nRsp++;
      end
      @(posedge clk);
      #1;
    end
    reqValidB = 1'b0;
    nCompared++;
    if (nRsp !== 16) begin
      nMismatched++;
      $display("[TB] FAIL b2b_count got %0d expected 16", nRsp);
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst_n       = 1'b0;
    reqValid    = 1'b0;
    reqWrite    = 1'b0;
    reqAddr     = 32'h0;
    reqWdata    = 32'h0;
    rspReady    = 1'b0;
    reqValidB   = 1'b0;
    reqWriteB   = 1'b0;
    reqAddrB    = 32'h0;
    reqWdataB   = 32'h0;
    rspReadyB   = 1'b0;
    $display("[TB] starting dmem_responder bench");
    test_reset();
    test_store_load();
    test_hold();
    test_wrap();
    test_align();
    test_reset_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
